vector_data_access_unit: RTL and testbench

- Memory-stage data-access sequencer. Sits between M-stage control/data and the 32-bit data memory port.
- Serialises each 128-bit vector load/store (AES state or round key) into LANES word beats.
- Drives BusyDA, which the hazard unit consumes to stall F/D/E/M/W while beats are in flight.
- Scalar accesses pass straight through in a single cycle with no stall.

---
 rtl/da_pkg.sv | 25 ++
 rtl/vector_data_access_unit_if.sv | 51 +++++
 rtl/vector_lane_buffer.sv | 35 +++
 rtl/vector_data_access_unit.sv | 138 +++++++++++++
 tb/tb_vector_data_access_unit.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/da_pkg.sv
// ---------------------------------------------------------------------------
// da_pkg
// Shared types and sizing constants for the vector data-access unit.
//   da_state_t        : sequencer states (idle / beat in flight / result valid)
//   DA_W              : memory port / scalar word width in bits
//   DA_LANES          : words per vector
//   DA_VW             : vector width in bits
//   DA_AW             : byte-address width
//   DA_BYTES_PER_BEAT : address stride between consecutive beats
// ---------------------------------------------------------------------------
package da_pkg;

  localparam int DA_W              = 32;
  localparam int DA_LANES          = 4;
  localparam int DA_VW             = DA_W * DA_LANES;
  localparam int DA_AW             = 32;
  localparam int DA_BYTES_PER_BEAT = DA_W / 8;

  typedef enum logic [1:0] {
    DA_IDLE = 2'd0,
    DA_BEAT = 2'd1,
    DA_DONE = 2'd2
  } da_state_t;

endpackage

// File: rtl/vector_data_access_unit_if.sv
// ---------------------------------------------------------------------------
// vector_data_access_unit_if
// Bundles the M-stage request/response signals and the 32-bit data memory
// port seen by the vector data-access unit.
//   slave  modport : the access unit (consumes M request, drives memory port)
//   master modport : the environment (pipeline M stage + data memory)
// Request/stall handshake: the M stage presents a request (MemReadM/MemWriteM
// with VecM) and holds it unchanged while BusyDA is high; BusyDA acts as the
// not-ready indication, and the instruction retires on the edge that ends
// the first cycle in which BusyDA is low.
// ---------------------------------------------------------------------------
interface vector_data_access_unit_if #(
  parameter int W     = da_pkg::DA_W,
  parameter int LANES = da_pkg::DA_LANES,
  parameter int AW    = da_pkg::DA_AW
);
  localparam int VW = W * LANES;

  // M-stage request side
  logic          MemReadM;
  logic          MemWriteM;
  logic          VecM;
  logic [AW-1:0] ALUResultM;
  logic [W-1:0]  WriteDataM;
  logic [VW-1:0] WriteDataVM;
  logic [W-1:0]  ReadDataM;
  logic [VW-1:0] ReadDataVM;
  logic          BusyDA;
  logic          MisalignDA;

  // Data memory port
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;

  modport slave (
    input  MemReadM, MemWriteM, VecM, ALUResultM, WriteDataM, WriteDataVM,
    input  mem_rdata,
    output ReadDataM, ReadDataVM, BusyDA, MisalignDA,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output MemReadM, MemWriteM, VecM, ALUResultM, WriteDataM, WriteDataVM,
    output mem_rdata,
    input  ReadDataM, ReadDataVM, BusyDA, MisalignDA,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/vector_lane_buffer.sv
// ---------------------------------------------------------------------------
// vector_lane_buffer
// LANES x W register file used to assemble vector load data one beat at a
// time. Each lane has its own write enable; all lanes read out flat.
//   clk, rst_n : clock, asynchronous active-low reset (clears all lanes)
//   we_i       : per-lane write enable
//   wdata_i    : word written into every enabled lane
//   rdata_o    : lane k at bits [W*k+W-1 : W*k]
// ---------------------------------------------------------------------------
module vector_lane_buffer #(
  parameter int W     = 32,
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LANES-1:0]     we_i,
  input  logic [W-1:0]         wdata_i,
  output logic [W*LANES-1:0]   rdata_o
);

  logic [LANES-1:0][W-1:0] lane_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (we_i[i]) lane_q[i] <= wdata_i;
      end
    end
  end

  assign rdata_o = lane_q;

endmodule

// File: rtl/vector_data_access_unit.sv
// ---------------------------------------------------------------------------
// vector_data_access_unit
// Memory-stage data-access sequencer. Scalar accesses pass straight through
// to the 32-bit data memory port in one cycle. A vector access is split into
// LANES word beats at the vector-aligned base address; BusyDA stays high
// while beats are issued so the hazard unit freezes the pipeline, then one
// DONE cycle presents the assembled load vector while the instruction retires.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : M-stage request/response and data memory port
//   dbg_state_o  : current sequencer state, for observation only
// Optional build macro DA_ALIGN_CHECK_EN: when defined, a vector request with
// non-zero low address bits sets the sticky MisalignDA flag (cleared only by
// reset); when undefined MisalignDA is constant 0.
// ---------------------------------------------------------------------------
module vector_data_access_unit
  import da_pkg::*;
#(
  parameter int W     = DA_W,
  parameter int LANES = DA_LANES,
  parameter int AW    = DA_AW
) (
  input  logic                             clk,
  input  logic                             rst_n,
  vector_data_access_unit_if.slave         bus,
  output da_state_t                        dbg_state_o
);

  localparam int VW       = W * LANES;
  localparam int KW       = $clog2(LANES);
  localparam int ALIGN_LG = $clog2(VW / 8);

  da_state_t     state_q;
  logic [KW-1:0] k_q;
  logic [AW-1:0] base_q;
  logic          store_q;

  logic          vec_req;
  logic          start;
  logic          active;
  logic          beat_store;
  logic [AW-1:0] req_base;
  logic [AW-1:0] beat_base;
  logic [AW-1:0] beat_addr;
  logic [W-1:0]  store_lane;
  logic [LANES-1:0] lane_we;
  logic [VW-1:0] lane_flat;

  assign vec_req  = bus.VecM & (bus.MemReadM | bus.MemWriteM);
  assign start    = (state_q == DA_IDLE) & vec_req;
  // Beat 0 goes out in the request cycle itself, so "active" covers the
  // IDLE start cycle plus every BEAT cycle: exactly LANES cycles.
  assign active   = start | (state_q == DA_BEAT);
  assign req_base = {bus.ALUResultM[AW-1:ALIGN_LG], {ALIGN_LG{1'b0}}};

  // Operation and base are captured at start so a request that drops
  // mid-sequence cannot change the remaining beats. Read+write is a store.
  assign beat_store = start ? bus.MemWriteM : store_q;
  assign beat_base  = start ? req_base : base_q;
  // k_q is 0 in IDLE, so the same adder serves beat 0 and later beats.
  assign beat_addr  = beat_base + (AW'(k_q) * AW'(DA_BYTES_PER_BEAT));
  assign store_lane = bus.WriteDataVM[k_q*W +: W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DA_IDLE;
      k_q     <= '0;
      base_q  <= '0;
      store_q <= 1'b0;
    end else begin
      case (state_q)
        DA_IDLE: begin
          if (vec_req) begin
            state_q <= DA_BEAT;
            k_q     <= KW'(1);
            base_q  <= req_base;
            store_q <= bus.MemWriteM;
          end
        end
        DA_BEAT: begin
          k_q <= k_q + KW'(1);
          if (k_q == KW'(LANES - 1)) state_q <= DA_DONE;
        end
        DA_DONE: begin
          // The request still visible here is the finishing instruction.
          state_q <= DA_IDLE;
          k_q     <= '0;
        end
        default: begin
          state_q <= DA_IDLE;
          k_q     <= '0;
        end
      endcase
    end
  end

`ifdef DA_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (start && (bus.ALUResultM[ALIGN_LG-1:0] != '0)) begin
      misalign_q <= 1'b1;
    end
  end

  assign bus.MisalignDA = misalign_q;
`else
  assign bus.MisalignDA = 1'b0;
`endif

  // Load beats capture mem_rdata into lane k at the edge ending the beat.
  assign lane_we = (active && !beat_store) ? (LANES'(1) << k_q) : '0;

  vector_lane_buffer #(
    .W     (W),
    .LANES (LANES)
  ) u_lane_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (lane_we),
    .wdata_i (bus.mem_rdata),
    .rdata_o (lane_flat)
  );

  // Outputs with combinational paths are gated by rst_n so that a reset
  // asserted mid-sequence silences the port immediately.
  assign bus.BusyDA     = rst_n & active;
  assign bus.mem_addr   = active ? beat_addr : bus.ALUResultM;
  assign bus.mem_wdata  = active ? store_lane : bus.WriteDataM;
  assign bus.mem_we     = rst_n & (active ? beat_store
                                          : ((state_q == DA_IDLE) & ~bus.VecM & bus.MemWriteM));
  assign bus.ReadDataM  = rst_n ? bus.mem_rdata : '0;
  assign bus.ReadDataVM = rst_n ? lane_flat : '0;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vector_data_access_unit.sv
module tb_vector_data_access_unit;
  import da_pkg::*;

  localparam int W  = DA_W;
  localparam int L  = DA_LANES;
  localparam int VW = DA_VW;
  localparam int AW = DA_AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_data_access_unit_if bus_if ();
  da_state_t dbg_state;

  vector_data_access_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [W-1:0] mem     [0:255];
  logic [W-1:0] ref_mem [0:255];
  logic         mem_load = 1'b0;

  assign bus_if.mem_rdata = mem[bus_if.mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_load) mem <= ref_mem;
    else if (bus_if.mem_we) mem[bus_if.mem_addr[9:2]] <= bus_if.mem_wdata;
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [AW+W-1:0] exp_q[$];
  logic [31:0] busy_trace = '0;

  always @(posedge clk) begin
    logic [AW+W-1:0] e;
    if (rst_n && bus_if.mem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                 bus_if.mem_addr, bus_if.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus_if.mem_addr, bus_if.mem_wdata} !== e) begin
          n_fail++;
          $display("FAIL write_order: got addr=%h data=%h, required addr=%h data=%h",
                   bus_if.mem_addr, bus_if.mem_wdata, e[AW+W-1:W], e[W-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: a vector read is the LANES consecutive words at the 16-byte
  // aligned base, lane c holding word c.
  function automatic logic [VW-1:0] model_vec_read(input logic [AW-1:0] addr);
    logic [VW-1:0] v;
    logic [7:0]    idx;
    v = '0;
    for (int c = 0; c < L; c++) begin
      idx = addr[9:2] - {6'd0, addr[3:2]} + 8'(c);
      v[c*W +: W] = ref_mem[idx];
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_idle();
    bus_if.MemReadM    = 1'b0;
    bus_if.MemWriteM   = 1'b0;
    bus_if.VecM        = 1'b0;
    bus_if.ALUResultM  = '0;
    bus_if.WriteDataM  = '0;
    bus_if.WriteDataVM = '0;
  endtask

  task automatic run_op(input logic vec, input logic rd, input logic wr,
                        input logic [AW-1:0] addr, input logic [W-1:0] wd,
                        input logic [VW-1:0] wdv, input logic [W-1:0] exp_rd,
                        input logic [VW-1:0] exp_rdv);
    logic [AW-1:0] base;
    bus_if.VecM        = vec;
    bus_if.MemReadM    = rd;
    bus_if.MemWriteM   = wr;
    bus_if.ALUResultM  = addr;
    bus_if.WriteDataM  = wd;
    bus_if.WriteDataVM = wdv;
    if (!vec) begin
      if (wr) begin
        exp_q.push_back({addr, wd});
        ref_mem[addr[9:2]] = wd;
      end
      @(negedge clk);
      busy_trace = {busy_trace[30:0], bus_if.BusyDA};
      check("scalar_busy", VW'(bus_if.BusyDA), VW'(1'b0));
      check("scalar_addr", VW'(bus_if.mem_addr), VW'(addr));
      check("scalar_we", VW'(bus_if.mem_we), VW'(wr));
      if (rd && !wr) check("scalar_rdata", VW'(bus_if.ReadDataM), VW'(exp_rd));
      @(posedge clk); #1;
    end else begin
      base = addr & ~AW'(32'hF);
      if (wr) begin
        for (int c = 0; c < L; c++) begin
          exp_q.push_back({base + AW'(4*c), wdv[c*W +: W]});
          ref_mem[base[9:2] + 8'(c)] = wdv[c*W +: W];
        end
      end
      for (int c = 0; c <= L; c++) begin
        @(negedge clk);
        busy_trace = {busy_trace[30:0], bus_if.BusyDA};
        if (c < L) begin
          check("vec_busy", VW'(bus_if.BusyDA), VW'(1'b1));
          check("vec_addr", VW'(bus_if.mem_addr), VW'(base + AW'(4*c)));
          check("vec_we", VW'(bus_if.mem_we), VW'(wr));
        end else begin
          check("done_busy", VW'(bus_if.BusyDA), VW'(1'b0));
          check("done_we", VW'(bus_if.mem_we), VW'(1'b0));
          if (!wr) check("done_rdv", bus_if.ReadDataVM, exp_rdv);
        end
        @(posedge clk); #1;
      end
    end
    drive_idle();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          vec;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  wd;
    logic [VW-1:0] wdv;
    logic [W-1:0]  exp_rd;
    logic [VW-1:0] exp_rdv;
  } vec_rec_t;

  vec_rec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VW-1:0] st_v;
    logic [VW-1:0] both_v;
    logic [VW-1:0] abort_v;
    logic          r_vec;
    logic          r_rd;
    logic          r_wr;
    logic [AW-1:0] r_addr;
    logic [W-1:0]  r_wd;
    logic [VW-1:0] r_wdv;
    int            kind;

    st_v    = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    both_v  = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;
    abort_v = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;

    tbl[0] = '{vec:1'b0, rd:1'b1, wr:1'b0, addr:32'h40,  wd:'0, wdv:'0,
               exp_rd:32'hDEADBEEF, exp_rdv:'0};
    tbl[1] = '{vec:1'b1, rd:1'b1, wr:1'b0, addr:32'h100, wd:'0, wdv:'0, exp_rd:'0,
               exp_rdv:128'h44444444_33333333_22222222_11111111};
    tbl[2] = '{vec:1'b1, rd:1'b0, wr:1'b1, addr:32'h200, wd:'0, wdv:st_v, exp_rd:'0, exp_rdv:'0};
    tbl[3] = '{vec:1'b1, rd:1'b1, wr:1'b0, addr:32'h200, wd:'0, wdv:'0, exp_rd:'0, exp_rdv:st_v};
    tbl[4] = '{vec:1'b0, rd:1'b0, wr:1'b1, addr:32'h44,  wd:32'hCAFEF00D, wdv:'0,
               exp_rd:'0, exp_rdv:'0};
    tbl[5] = '{vec:1'b0, rd:1'b1, wr:1'b0, addr:32'h44,  wd:'0, wdv:'0,
               exp_rd:32'hCAFEF00D, exp_rdv:'0};
    tbl[6] = '{vec:1'b1, rd:1'b1, wr:1'b1, addr:32'h300, wd:'0, wdv:both_v, exp_rd:'0, exp_rdv:'0};
    tbl[7] = '{vec:1'b1, rd:1'b1, wr:1'b0, addr:32'h300, wd:'0, wdv:'0, exp_rd:'0, exp_rdv:both_v};

    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[32'h40 >> 2]  = 32'hDEADBEEF;
    ref_mem[32'h100 >> 2] = 32'h11111111;
    ref_mem[32'h104 >> 2] = 32'h22222222;
    ref_mem[32'h108 >> 2] = 32'h33333333;
    ref_mem[32'h10C >> 2] = 32'h44444444;

    // Reset held: load memory, and show a vector request cannot raise BusyDA.
    drive_idle();
    mem_load = 1'b1;
    @(posedge clk); #1;
    mem_load = 1'b0;
    bus_if.VecM = 1'b1;
    bus_if.MemReadM = 1'b1;
    bus_if.ALUResultM = 32'h100;
    #1;
    check("rst_busy", VW'(bus_if.BusyDA), VW'(1'b0));
    check("rst_we", VW'(bus_if.mem_we), VW'(1'b0));
    check("rst_state", VW'(dbg_state), VW'(DA_IDLE));
    check("rst_rdv", bus_if.ReadDataVM, '0);
    check("rst_rd", VW'(bus_if.ReadDataM), '0);
    check("rst_misalign", VW'(bus_if.MisalignDA), VW'(1'b0));
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven directed vectors; entries 1 and 2 run back to back.
    for (int i = 0; i < 8; i++) begin
      if (i == 1) busy_trace = '0;
      run_op(tbl[i].vec, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd,
             tbl[i].wdv, tbl[i].exp_rd, tbl[i].exp_rdv);
      if (i == 2) check("b2b_busy_pattern", VW'(busy_trace[9:0]), VW'(10'b1111011110));
    end

    // Unaligned vector load runs at the aligned base.
`ifdef DA_ALIGN_CHECK_EN
    check("misalign_before", VW'(bus_if.MisalignDA), VW'(1'b0));
    run_op(1'b1, 1'b1, 1'b0, 32'h104, '0, '0, '0, model_vec_read(32'h104));
    check("misalign_set", VW'(bus_if.MisalignDA), VW'(1'b1));
    run_op(1'b1, 1'b1, 1'b0, 32'h200, '0, '0, '0, model_vec_read(32'h200));
    check("misalign_sticky", VW'(bus_if.MisalignDA), VW'(1'b1));
`else
    run_op(1'b1, 1'b1, 1'b0, 32'h104, '0, '0, '0, model_vec_read(32'h104));
    check("misalign_off", VW'(bus_if.MisalignDA), VW'(1'b0));
`endif

    // Reset during beat 2 of a vector store: only beats 0 and 1 land.
    exp_q.push_back({32'h200, abort_v[31:0]});
    exp_q.push_back({32'h204, abort_v[63:32]});
    ref_mem[32'h200 >> 2] = abort_v[31:0];
    ref_mem[32'h204 >> 2] = abort_v[63:32];
    bus_if.VecM = 1'b1;
    bus_if.MemWriteM = 1'b1;
    bus_if.ALUResultM = 32'h200;
    bus_if.WriteDataVM = abort_v;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    check("abort_busy_pre", VW'(bus_if.BusyDA), VW'(1'b1));
    check("abort_addr_pre", VW'(bus_if.mem_addr), VW'(32'h208));
    rst_n = 1'b0;
    #1;
    check("abort_busy", VW'(bus_if.BusyDA), VW'(1'b0));
    check("abort_we", VW'(bus_if.mem_we), VW'(1'b0));
    check("abort_state", VW'(dbg_state), VW'(DA_IDLE));
    check("abort_misalign", VW'(bus_if.MisalignDA), VW'(1'b0));
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_state_after", VW'(dbg_state), VW'(DA_IDLE));
    run_op(1'b1, 1'b1, 1'b0, 32'h200, '0, '0, '0, model_vec_read(32'h200));

    // Randomized operations against the reference memory.
    for (int n = 0; n < 40; n++) begin
      r_vec = 1'($urandom_range(0, 1));
      kind  = $urandom_range(0, 2);
      r_rd  = (kind != 1);
      r_wr  = (kind != 0);
      r_addr = r_vec ? AW'($urandom_range(0, 1023)) : AW'({$urandom_range(0, 255), 2'b00});
      r_wd  = $urandom;
      r_wdv = {$urandom, $urandom, $urandom, $urandom};
      run_op(r_vec, r_rd, r_wr, r_addr, r_wd, r_wdv,
             ref_mem[r_addr[9:2]], model_vec_read(r_addr));
    end

    repeat (2) @(posedge clk);
    #1;
    check("writes_outstanding", VW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
